prog_ram: RTL
=============

# prog_ram

Loadable, parametrised program memory replacing the fixed program ROM in the cpu15 fetch stage. After reset the block clears its array to a fill word. It then accepts a program over a valid/ready loader port, and serves registered instruction fetches addressed by the program counter. Reloading at run time is supported without a reset.

## Interface
Parameters:
- WORD_W, 15: instruction word width.
- ADDR_W, 8: program-counter width; DEPTH = 2**ADDR_W words.
- FILL_WORD, 15'b0: value written by the clear sweep and driven on PROM_OUT when not valid.

Ports:
- CLK_FT  in  1  single clock; all state changes on its rising edge.
- RST_FT  in  1  synchronous, active-high reset.
- LD_START  in  1  request to enter LOAD; honoured only in RUN.
- LD_VALID  in  1  loader word present.
- LD_DATA  in  WORD_W  loader word.
- LD_LAST  in  1  marks the final loader word.
- LD_READY  out  1  high only in LOAD.
- LD_COUNT  out  ADDR_W+1  words accepted in the current or last load.
- P_COUNT  in  ADDR_W  fetch address.
- PROM_OUT  out  WORD_W  fetched instruction.
- PROM_VALID  out  1  PROM_OUT is a real fetch.
- PROM_ERR  out  1  parity error on the current PROM_OUT (see Configuration).

## Operation
States: CLEAR, LOAD, RUN.
- CLEAR (entered on reset):
  - Writes FILL_WORD to addresses 0..DEPTH-1, one per cycle.
  - Moves to LOAD on the cycle after address DEPTH-1 is written.
  - LD_START and fetches are ignored.
- LOAD:
  - LD_READY=1. A beat is accepted when LD_VALID & LD_READY.
  - Each accepted beat writes LD_DATA to mem[wr_ptr], increments wr_ptr and increments LD_COUNT.
  - Moves to RUN after a beat with LD_LAST=1, or after the beat written at address DEPTH-1; in that case LD_COUNT=DEPTH.
  - Words that were not loaded keep their previous contents.
  - LD_START is ignored.
- RUN:
  - Each cycle: PROM_OUT <= mem[P_COUNT], PROM_VALID <= 1.
  - LD_START=1 moves to LOAD on the next edge and clears wr_ptr and LD_COUNT to 0. The array is not cleared.
- Outside RUN, PROM_OUT is registered to FILL_WORD and PROM_VALID is registered to 0.
- Reset values: state CLEAR, PROM_OUT=FILL_WORD, PROM_VALID=0, PROM_ERR=0, LD_READY=0, LD_COUNT=0, wr_ptr=0.

## Timing
- Fetch latency is 1 cycle: P_COUNT sampled at edge n appears on PROM_OUT after edge n, and is held until the next edge.
- The clear sweep takes DEPTH cycles after reset deasserts. LD_READY rises on edge DEPTH+1.
- LOAD->RUN: PROM_VALID first rises one edge after the transition edge. It is the fetch of the P_COUNT sampled in the first RUN cycle.
- RUN->LOAD: PROM_VALID falls on the same edge the state changes. LD_READY is high in the following cycle.
- No read and write ever occur in the same cycle, so read-during-write ordering is undefined and need not be handled.
- Simultaneous events:
  - RST_FT wins over everything.
  - LD_START with RST_FT has no effect.
  - LD_LAST on the address DEPTH-1 beat causes a single transition.
- RST_FT mid-LOAD or mid-RUN returns to CLEAR. The array is re-cleared and the loaded program is lost.
- LD_VALID held low in LOAD waits indefinitely. There is no timeout.

## Configuration
- PROM_PARITY_EN:
  - Defined: the array is WORD_W+1 bits wide. An even-parity bit is computed on every write, in both CLEAR and LOAD.
  - Defined: on each RUN fetch, PROM_ERR is registered alongside PROM_OUT. It is 1 when the stored parity mismatches the stored word.
  - Defined: PROM_ERR is 0 whenever PROM_VALID=0.
  - Not defined: the array is WORD_W bits wide and PROM_ERR is constant 0.

## Structure
- Shared package cpu15_pkg holds:
  - the state enum (CLEAR, LOAD, RUN);
  - the default WORD_W and ADDR_W;
  - the NOP/FILL word constant.
- One sub-module, prog_ram_array: a synchronous-write, registered-read single-port array with a width parameter.
- The FSM, counters and parity logic stay in prog_ram.

## Test plan
- Reset, then idle:
  - LD_READY stays 0 for exactly DEPTH cycles (256 at defaults) and then rises.
  - PROM_VALID=0 and PROM_OUT=0 throughout.
- Load 3 words, 15'h4800 / 15'h4000 / 15'h7800, with LD_LAST on the third:
  - LD_COUNT=3 and the state is RUN.
  - Fetching P_COUNT=0,1,2,3 yields 15'h4800, 15'h4000, 15'h7800, 0, each one cycle later with PROM_VALID=1.
- Loader backpressure: LD_VALID toggled 1,0,1,0,1 with LD_LAST on the last word:
  - Exactly 3 words are written, at addresses 0..2.
  - LD_COUNT=3.
- Full load of 256 words with no LD_LAST:
  - Auto-transition to RUN after the 256th beat, with LD_COUNT=256.
  - Fetching address 8'hFF returns the last word.
- Reload: in RUN, pulse LD_START and load 1 word, 15'h1234:
  - Address 0 returns 15'h1234 and address 1 keeps its old word.
  - PROM_VALID is low from the LD_START edge until RUN resumes.
- Reset mid-load after 2 beats:
  - The bench sees the CLEAR sweep again.
  - All addresses read 0 after the next 1-word load except address 0.
  - With PROM_PARITY_EN defined, PROM_ERR stays 0 throughout.

Source files
------------

// File: rtl/cpu15_pkg.sv
// Shared cpu15 definitions: program-memory FSM states, default widths and the NOP/fill word.
package cpu15_pkg;

    localparam int CPU15_WORD_W = 15;
    localparam int CPU15_ADDR_W = 8;

    localparam logic [CPU15_WORD_W-1:0] CPU15_NOP_WORD = '0;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } prom_state_t;

endpackage

// File: rtl/prog_ram_array.sv
// Single-port program storage: synchronous write, registered read, width set by DATA_W.
module prog_ram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the storage so it maps onto block RAM; the owner sweeps it clean.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/prog_ram.sv
// Loadable program memory for the cpu15 fetch stage: clear sweep, valid/ready loader, registered fetch.
// Defining PROM_PARITY_EN stores an even-parity bit per word and reports mismatches on PROM_ERR.
module prog_ram
    import cpu15_pkg::*;
#(
    parameter int                WORD_W    = CPU15_WORD_W,
    parameter int                ADDR_W    = CPU15_ADDR_W,
    parameter logic [WORD_W-1:0] FILL_WORD = CPU15_NOP_WORD
) (
    input  logic              CLK_FT,
    input  logic              RST_FT,
    input  logic              LD_START,
    input  logic              LD_VALID,
    input  logic [WORD_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              LD_READY,
    output logic [ADDR_W:0]   LD_COUNT,
    input  logic [ADDR_W-1:0] P_COUNT,
    output logic [WORD_W-1:0] PROM_OUT,
    output logic              PROM_VALID,
    output logic              PROM_ERR
);

`ifdef PROM_PARITY_EN
    localparam int ARR_W = WORD_W + 1;
`else
    localparam int ARR_W = WORD_W;
`endif

    prom_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;
    logic              ld_ready_q, ld_ready_d;
    logic              prom_valid_q, prom_valid_d;

    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] word_wr;
    logic [ARR_W-1:0]  mem_wdata;
    logic [ARR_W-1:0]  mem_rdata;

    // wr_ptr doubles as the sweep address in CLEAR and the load address in LOAD.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        ld_count_d = ld_count_q;
        mem_we     = 1'b0;
        word_wr    = FILL_WORD;

        case (state_q)
            ST_CLEAR: begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (&wr_ptr_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (LD_VALID && ld_ready_q) begin
                    mem_we     = 1'b1;
                    word_wr    = LD_DATA;
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    ld_count_d = ld_count_q + (ADDR_W+1)'(1);
                    if (LD_LAST || (&wr_ptr_q)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (LD_START) begin
                    state_d    = ST_LOAD;
                    wr_ptr_d   = '0;
                    ld_count_d = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        ld_ready_d   = (state_d == ST_LOAD);
        // A fetch only counts when RUN is both the current and the next state.
        prom_valid_d = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge CLK_FT) begin
        if (RST_FT) begin
            state_q      <= ST_CLEAR;
            wr_ptr_q     <= '0;
            ld_count_q   <= '0;
            ld_ready_q   <= 1'b0;
            prom_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            ld_count_q   <= ld_count_d;
            ld_ready_q   <= ld_ready_d;
            prom_valid_q <= prom_valid_d;
        end
    end

    assign mem_re   = (state_q == ST_RUN);
    assign mem_addr = (state_q == ST_RUN) ? P_COUNT : wr_ptr_q;

`ifdef PROM_PARITY_EN
    assign mem_wdata = {^word_wr, word_wr};
`else
    assign mem_wdata = word_wr;
`endif

    prog_ram_array #(
        .DATA_W (ARR_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (CLK_FT),
        .we    (mem_we && !RST_FT),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign LD_READY   = ld_ready_q;
    assign LD_COUNT   = ld_count_q;
    assign PROM_VALID = prom_valid_q;
    assign PROM_OUT   = prom_valid_q ? mem_rdata[WORD_W-1:0] : FILL_WORD;

`ifdef PROM_PARITY_EN
    // Stored word plus its parity bit must XOR to zero; anything else is corruption.
    assign PROM_ERR = prom_valid_q && (^mem_rdata);
`else
    assign PROM_ERR = 1'b0;
`endif

endmodule
